// File: rtl/op_dispatcher_pkg.sv
// Shared types for the op_dispatcher front-end.
//   op_type_t : 2-bit command encoding seen on op_type / resp_type
//   state_t   : dispatcher FSM states
//   req_onehot: maps a command to its request strobe, bit index == encoding
//               {deq_back, deq_front, enq_front, enq_back}
package op_dispatcher_pkg;

  typedef enum logic [1:0] {
    OpEnqBack  = 2'd0,
    OpEnqFront = 2'd1,
    OpDeqFront = 2'd2,
    OpDeqBack  = 2'd3
  } op_type_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_t;

  function automatic logic [3:0] req_onehot(op_type_t op);
    return 4'b0001 << op;
  endfunction

endpackage

// File: rtl/op_dispatcher_occ.sv
// Saturating up/down occupancy counter for the downstream queue.
// Only instantiated when OP_DISPATCH_OCC_TRACK_EN is defined.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   inc, dec    : one-cycle count strobes (enqueue / dequeue completion)
//   full, empty : count == p_depth / count == 0
module op_dispatcher_occ #(
  parameter int unsigned p_depth = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int unsigned CntW = $clog2(p_depth + 1);

  logic [CntW-1:0] count_q;

  assign full  = (count_q == CntW'(p_depth));
  assign empty = (count_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && !dec && !full) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc && !empty) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/op_dispatcher.sv
// Front-end for the double-ended queue: accepts one {op, data} command at a
// time, issues it on exactly one of the four queue req/cpl interfaces and
// returns {op, data, err} on a val/rdy response channel.
// Optional feature: define OP_DISPATCH_OCC_TRACK_EN to track occupancy and
// reject enqueue-when-full / dequeue-when-empty without touching the queue.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   op_val/op_rdy/op_type/op_data  : command channel
//   resp_val/resp_rdy/resp_*       : response channel (registered, held in RESP)
//   *_req / *_cpl                  : queue request strobes / completion pulses
//   enq_*_data                     : latched payload, stable while a req is high
//   deq_*_data                     : dequeued data, valid in the cpl cycle
module op_dispatcher
  import op_dispatcher_pkg::*;
#(
  parameter int unsigned p_depth    = 32,
  parameter int unsigned p_bitwidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_val,
  output logic                  op_rdy,
  input  logic [1:0]            op_type,
  input  logic [p_bitwidth-1:0] op_data,
  output logic                  resp_val,
  input  logic                  resp_rdy,
  output logic [1:0]            resp_type,
  output logic [p_bitwidth-1:0] resp_data,
  output logic                  resp_err,
  output logic                  enq_back_req,
  output logic                  enq_front_req,
  output logic                  deq_front_req,
  output logic                  deq_back_req,
  input  logic                  enq_back_cpl,
  input  logic                  enq_front_cpl,
  input  logic                  deq_front_cpl,
  input  logic                  deq_back_cpl,
  output logic [p_bitwidth-1:0] enq_back_data,
  output logic [p_bitwidth-1:0] enq_front_data,
  input  logic [p_bitwidth-1:0] deq_front_data,
  input  logic [p_bitwidth-1:0] deq_back_data
);

  state_t                state_q;
  op_type_t              type_q;
  logic [p_bitwidth-1:0] data_q;
  logic [3:0]            req_q;
  logic [3:0]            cpl_vec;
  logic                  cpl_hit;
  logic                  accept;
  logic                  reject;
  op_type_t              op_in;

  assign op_in   = op_type_t'(op_type);
  assign op_rdy  = (state_q == StIdle);
  assign accept  = op_val && op_rdy;
  assign cpl_vec = {deq_back_cpl, deq_front_cpl, enq_front_cpl, enq_back_cpl};
  // Only the completion of the interface we actually requested counts.
  assign cpl_hit = (state_q == StIssue) && |(cpl_vec & req_q);

  assign {deq_back_req, deq_front_req, enq_front_req, enq_back_req} = req_q;
  assign enq_back_data  = data_q;
  assign enq_front_data = data_q;

`ifdef OP_DISPATCH_OCC_TRACK_EN
  logic occ_full;
  logic occ_empty;

  op_dispatcher_occ #(
    .p_depth(p_depth)
  ) u_occ (
    .clk  (clk),
    .rst  (rst),
    .inc  (cpl_hit && !type_q[1]),
    .dec  (cpl_hit && type_q[1]),
    .full (occ_full),
    .empty(occ_empty)
  );

  // op_type[1] set means a dequeue.
  assign reject = op_type[1] ? occ_empty : occ_full;
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      type_q    <= OpEnqBack;
      data_q    <= '0;
      req_q     <= '0;
      resp_val  <= 1'b0;
      resp_type <= 2'd0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            type_q    <= op_in;
            data_q    <= op_data;
            resp_type <= op_type;
            if (reject) begin
              // Rejected commands bypass the queue entirely.
              state_q   <= StResp;
              resp_val  <= 1'b1;
              resp_err  <= 1'b1;
              resp_data <= '0;
            end else begin
              state_q  <= StIssue;
              req_q    <= req_onehot(op_in);
              resp_err <= 1'b0;
            end
          end
        end
        StIssue: begin
          if (cpl_hit) begin
            req_q    <= '0;
            resp_val <= 1'b1;
            state_q  <= StResp;
            unique case (type_q)
              OpDeqFront: resp_data <= deq_front_data;
              OpDeqBack:  resp_data <= deq_back_data;
              default:    resp_data <= '0;
            endcase
          end
        end
        StResp: begin
          if (resp_rdy) begin
            resp_val <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A completion on an interface that is not currently requested is a queue
  // protocol error; the FSM ignores it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stray_cpl: assert ((cpl_vec & ~req_q) == 4'b0000);
    end
  end

endmodule

// File: tb/tb_op_dispatcher.sv
// Self-checking bench for op_dispatcher (p_depth = 4). The bench plays the
// queue itself (a deque answering req strobes) and predicts every response
// from a separate behavioural deque model of the command stream.
module tb_op_dispatcher;

  localparam int unsigned Depth = 4;
  localparam int unsigned Bw    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_val;
  logic          op_rdy;
  logic [1:0]    op_type;
  logic [Bw-1:0] op_data;
  logic          resp_val;
  logic          resp_rdy;
  logic [1:0]    resp_type;
  logic [Bw-1:0] resp_data;
  logic          resp_err;
  logic          enq_back_req, enq_front_req, deq_front_req, deq_back_req;
  logic          enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl;
  logic [Bw-1:0] enq_back_data, enq_front_data, deq_front_data, deq_back_data;

  op_dispatcher #(
    .p_depth   (Depth),
    .p_bitwidth(Bw)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .op_val        (op_val),
    .op_rdy        (op_rdy),
    .op_type       (op_type),
    .op_data       (op_data),
    .resp_val      (resp_val),
    .resp_rdy      (resp_rdy),
    .resp_type     (resp_type),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .enq_back_req  (enq_back_req),
    .enq_front_req (enq_front_req),
    .deq_front_req (deq_front_req),
    .deq_back_req  (deq_back_req),
    .enq_back_cpl  (enq_back_cpl),
    .enq_front_cpl (enq_front_cpl),
    .deq_front_cpl (deq_front_cpl),
    .deq_back_cpl  (deq_back_cpl),
    .enq_back_data (enq_back_data),
    .enq_front_data(enq_front_data),
    .deq_front_data(deq_front_data),
    .deq_back_data (deq_back_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [Bw-1:0] bq[$];  // contents of the simulated queue
  logic [Bw-1:0] rq[$];  // reference model contents

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [3:0] req_vec();
    return {deq_back_req, deq_front_req, enq_front_req, enq_back_req};
  endfunction

  // Reference: 0 ENQ_BACK, 1 ENQ_FRONT, 2 DEQ_FRONT, 3 DEQ_BACK on a deque of
  // capacity Depth. Without occupancy tracking a full enqueue is dropped by
  // the queue and an empty dequeue returns 0.
  task automatic model(input logic [1:0] op, input logic [Bw-1:0] d, output logic [Bw-1:0] ed,
                       output logic ee, output logic iss);
    ed = '0; ee = 1'b0; iss = 1'b1;
    if (op < 2) begin
      if (rq.size() < Depth) begin
        if (op == 0) rq.push_back(d);
        else rq.push_front(d);
      end else begin
`ifdef OP_DISPATCH_OCC_TRACK_EN
        ee = 1'b1; iss = 1'b0;
`endif
      end
    end else begin
      if (rq.size() > 0) begin
        if (op == 2) ed = rq.pop_front();
        else ed = rq.pop_back();
      end else begin
`ifdef OP_DISPATCH_OCC_TRACK_EN
        ee = 1'b1; iss = 1'b0;
`endif
      end
    end
  endtask

  task automatic clear_cpl();
    {enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl} = '0;
    deq_front_data = $urandom;
    deq_back_data  = $urandom;
  endtask

  // Queue side: complete whichever interface is requested.
  task automatic respond(input logic [3:0] rv);
    if (rv[0]) begin
      enq_back_cpl = 1'b1;
      if (bq.size() < Depth) bq.push_back(enq_back_data);
    end else if (rv[1]) begin
      enq_front_cpl = 1'b1;
      if (bq.size() < Depth) bq.push_front(enq_front_data);
    end else if (rv[2]) begin
      deq_front_cpl  = 1'b1;
      deq_front_data = (bq.size() > 0) ? bq.pop_front() : '0;
    end else begin
      deq_back_cpl  = 1'b1;
      deq_back_data = (bq.size() > 0) ? bq.pop_back() : '0;
    end
  endtask

  // One full command: dly = extra cycles req is held before cpl,
  // stall = cycles resp_rdy is held low once the response is up.
  task automatic do_op(input logic [1:0] op, input logic [Bw-1:0] d, input int dly,
                       input int stall);
    logic [Bw-1:0] ed, hold_data;
    logic          ee, iss, got, bad_req, bad_dat, bad_stall;
    logic [3:0]    rv;
    int            k, req_cycles, waited;
    model(op, d, ed, ee, iss);
    @(negedge clk);
    waited = 0;
    while (!op_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("op_rdy_before", op_rdy, 1);
    op_val = 1'b1; op_type = op; op_data = d;
    k = 0; req_cycles = 0; got = 0; bad_req = 0; bad_dat = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      op_val = 1'b0;
      op_data = $urandom;
      clear_cpl();
      rv = req_vec();
      if (rv != 4'b0) begin
        req_cycles++;
        if (rv != (4'b0001 << op)) bad_req = 1;
        if (rv[0] && enq_back_data !== d) bad_dat = 1;
        if (rv[1] && enq_front_data !== d) bad_dat = 1;
        if (req_cycles == dly + 1) respond(rv);
      end
      if (resp_val) got = 1;
    end
    if (!got) begin
      check("resp_timeout", 0, 1);
      clear_cpl();
      return;
    end
    check("resp_type", resp_type, op);
    check("resp_data", resp_data, ed);
    check("resp_err", resp_err, ee);
    check("latency", k, iss ? dly + 2 : 1);
    check("req_cycles", req_cycles, iss ? dly + 1 : 0);
    check("req_onehot", bad_req, 0);
    check("enq_data", bad_dat, 0);
    if (stall > 0) begin
      hold_data = resp_data;
      bad_stall = 0;
      resp_rdy = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        clear_cpl();
        if (!resp_val || resp_data !== hold_data || op_rdy || req_vec() != 4'b0) bad_stall = 1;
      end
      check("stall_hold", bad_stall, 0);
      resp_rdy = 1'b1;
    end
    @(negedge clk);
    clear_cpl();
    check("back_idle", {resp_val, op_rdy, req_vec()}, 6'b010000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bq.delete();
    rq.delete();
  endtask

  initial begin
    rst = 1'b1; op_val = 1'b0; op_type = '0; op_data = '0; resp_rdy = 1'b1;
    clear_cpl();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {op_rdy, resp_val, resp_err, req_vec(), resp_type},
          {1'b1, 1'b0, 1'b0, 4'b0, 2'b0});
    check("reset_data", resp_data, 0);

    // Back-to-back minimum round trips, then mixed-end ordering.
    do_op(2'd0, 32'hA, 0, 0);
    do_op(2'd0, 32'hB, 0, 0);
    do_op(2'd2, 32'h0, 0, 0);
    do_op(2'd2, 32'h0, 2, 0);
    do_op(2'd1, 32'h1, 1, 0);
    do_op(2'd0, 32'h2, 0, 0);
    do_op(2'd3, 32'h0, 3, 0);
    do_op(2'd2, 32'h0, 0, 0);

    // Back-pressure on a dequeue response.
    do_op(2'd0, 32'h5A5A, 0, 0);
    do_op(2'd2, 32'h0, 1, 5);

    // Reset while deq_back_req is pending.
    do_op(2'd0, 32'h77, 0, 0);
    @(negedge clk);
    op_val = 1'b1; op_type = 2'd3;
    @(negedge clk);
    op_val = 1'b0;
    check("mid_req", req_vec(), 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bq.delete();
    rq.delete();
    check("mid_reset", {req_vec(), resp_val, op_rdy}, 6'b000001);
    do_op(2'd3, 32'h0, 0, 0);

    // Fill past capacity, then drain past empty.
    do_reset();
    for (int i = 0; i < 5; i++) do_op(2'd0, 32'h100 + i, 0, 0);
    for (int i = 0; i < 5; i++) do_op(2'd2, 32'h0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      do_op(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
